game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
- Top-level game controller for the scrolling-bar environment.
- Sequences play, pause, crash, level-up and game-over.
- Drives the environment's `pause` and `level` inputs and a divided step enable that paces bar motion.
- Tracks score and lives from collision and bar-passed events; sits between the input/debounce logic, the collision detector, the environment block and the display/score renderer.

Parameters:
- BARS_PER_LEVEL, 8: bars cleared before advancing a level (>=1).
- MAX_LEVEL, 9: highest level; level saturates here.
- LIVES, 3: lives at game start (1..3).
- STEP_DIV, 4: frame ticks per env_step pulse (>=1).
- CRASH_HOLD, 60: frame ticks spent frozen in CRASH (>=1).

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- btn_start  in  1  debounced one-cycle start pulse.
- btn_pause  in  1  debounced one-cycle pause-toggle pulse.
- collision  in  1  level signal, player overlaps bar.
- bar_passed  in  1  one-cycle pulse, player cleared a bar.
- pause  out  1  freeze to environment (1 = frozen).
- env_step  out  1  one-cycle pulse, advance bar positions.
- level  out  10  current level, 1..MAX_LEVEL.
- score  out  10  bars cleared this game, saturating.
- lives  out  2  remaining lives.
- state  out  3  FSM state code.
- game_over  out  1  high while in OVER.

Behaviour:
- All outputs registered.
- Reset (async, rst=1): state=IDLE, pause=1, env_step=0, level=1, score=0, lives=LIVES, game_over=0; div_cnt, bar_cnt and hold_cnt all 0.
- State codes: IDLE=0, PLAY=1, PAUSED=2, CRASH=3, LEVEL_UP=4, OVER=5.
- IDLE:
  - pause=1.
  - btn_start -> PLAY next cycle; level=1, score=0, lives=LIVES, counters cleared.
  - All other inputs ignored.
- PLAY:
  - pause=0.
  - Each frame_tick increments div_cnt. When div_cnt==STEP_DIV-1, env_step=1 for exactly the cycle after that frame_tick, and div_cnt returns to 0.
  - Event priority in one cycle: collision > btn_pause > bar_passed.
  - collision -> CRASH; lives decremented by 1 on the transition; score not incremented even if bar_passed is simultaneous.
  - btn_pause (no collision) -> PAUSED; a simultaneous bar_passed is lost.
  - bar_passed alone: score+1 (saturate at 1023), bar_cnt+1.
  - If bar_cnt==BARS_PER_LEVEL-1 at a bar_passed -> LEVEL_UP.
- PAUSED:
  - pause=1, env_step=0; div_cnt, bar_cnt, score, level held.
  - btn_pause -> PLAY.
  - collision, bar_passed, btn_start ignored.
- CRASH:
  - pause=1, env_step=0.
  - hold_cnt counts frame_ticks.
  - At the frame_tick where hold_cnt==CRASH_HOLD-1: if lives==0 -> OVER, else -> PLAY with bar_cnt=0, div_cnt=0, hold_cnt=0.
  - collision is level-sensitive and is ignored while in CRASH. It is not re-detected until the cycle after re-entering PLAY, so the collision detector must deassert within CRASH_HOLD frames.
- LEVEL_UP:
  - Lasts exactly one cycle; pause=1.
  - level=level+1 if level<MAX_LEVEL, else unchanged.
  - bar_cnt=0, div_cnt=0 -> PLAY.
- OVER:
  - game_over=1, pause=1; score and level hold for display.
  - btn_start -> IDLE.
- env_step is never 1 outside PLAY.
- frame_tick arriving in the same cycle as a transition out of PLAY does not generate env_step.
- lives is never decremented below 0.
- Reset asserted mid-game returns to the reset state immediately, including mid-CRASH.

Optional Feature:
- Macro: GAME_SEQUENCER_SPEEDUP_EN.
- Defined: effective divider = max(1, STEP_DIV-(level-1)), recomputed at each level change; bars move faster at higher levels.
- Undefined: divider fixed at STEP_DIV for every level.

Test Plan:
- Reset, then btn_start, then 8 frame_ticks (STEP_DIV=4) -> state=1, pause=0, exactly 2 env_step pulses, each 1 cycle after the 4th and 8th frame_tick.
- In PLAY, 8 bar_passed pulses (BARS_PER_LEVEL=8) -> score=8, one cycle in state=4, then state=1 with level=2. Repeat at level=MAX_LEVEL=9 -> level stays 9.
- In PLAY, collision and bar_passed in the same cycle -> state=3, lives 3->2, score unchanged. After 60 frame_ticks -> state=1, pause=0.
- Three collisions, each followed by the CRASH hold -> lives=0, state=5, game_over=1. Then btn_start -> state=0, and a second btn_start -> level=1, score=0, lives=3.
- btn_pause in PLAY -> state=2, no env_step over 10 frame_ticks, bar_passed ignored. btn_pause again -> state=1 with div_cnt resumed from its held value.
- Assert rst mid-CRASH -> asynchronously state=0, pause=1, lives=3, score=0, env_step=0. With GAME_SEQUENCER_SPEEDUP_EN at level=3 -> env_step every 2 frame_ticks.

Source files
------------

// File: rtl/game_sequencer_if.sv
// game_sequencer_if
//   Groups the game controller's event inputs and status outputs.
//   master : the side that produces frame/button/collision events and
//            consumes the controller status (input logic, test harness).
//   slave  : the game controller itself.
//   Signals:
//     frame_tick  one-cycle pulse per video frame
//     btn_start   debounced one-cycle start pulse
//     btn_pause   debounced one-cycle pause-toggle pulse
//     collision   level signal, player overlaps a bar
//     bar_passed  one-cycle pulse, player cleared a bar
//     pause       freeze request to the environment (1 = frozen)
//     env_step    one-cycle pulse, advance bar positions
//     level       current level, 1..MAX_LEVEL
//     score       bars cleared this game, saturating at 1023
//     lives       remaining lives
//     state       FSM state code
//     game_over   high while the game is over
interface game_sequencer_if;
  logic       frame_tick;
  logic       btn_start;
  logic       btn_pause;
  logic       collision;
  logic       bar_passed;
  logic       pause;
  logic       env_step;
  logic [9:0] level;
  logic [9:0] score;
  logic [1:0] lives;
  logic [2:0] state;
  logic       game_over;

  modport master (
    output frame_tick, btn_start, btn_pause, collision, bar_passed,
    input  pause, env_step, level, score, lives, state, game_over
  );

  modport slave (
    input  frame_tick, btn_start, btn_pause, collision, bar_passed,
    output pause, env_step, level, score, lives, state, game_over
  );
endinterface

// File: rtl/game_sequencer.sv
// game_sequencer
//   Top-level game controller for the scrolling-bar environment. Sequences
//   IDLE -> PLAY <-> PAUSED, PLAY -> CRASH -> PLAY/OVER and
//   PLAY -> LEVEL_UP -> PLAY, paces bar motion with a frame-tick divider and
//   tracks score, lives and level.
//   Ports:
//     clk  system clock
//     rst  asynchronous active-high reset
//     bus  game_sequencer_if.slave (event inputs, registered status outputs)
//   Optional feature: define GAME_SEQUENCER_SPEEDUP_EN to shrink the
//   env_step divider by one per level above 1 (never below 1).
module game_sequencer #(
  parameter int BARS_PER_LEVEL = 8,
  parameter int MAX_LEVEL      = 9,
  parameter int LIVES          = 3,
  parameter int STEP_DIV       = 4,
  parameter int CRASH_HOLD     = 60
) (
  input logic             clk,
  input logic             rst,
  game_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PLAY     = 3'd1,
    S_PAUSED   = 3'd2,
    S_CRASH    = 3'd3,
    S_LEVEL_UP = 3'd4,
    S_OVER     = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        pause_q, pause_d;
  logic        env_step_q, env_step_d;
  logic        game_over_q, game_over_d;
  logic [9:0]  level_q, level_d;
  logic [9:0]  score_q, score_d;
  logic [1:0]  lives_q, lives_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic [15:0] bar_cnt_q, bar_cnt_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic [15:0] step_last;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  // Terminal value of div_cnt: divider minus one.
`ifdef GAME_SEQUENCER_SPEEDUP_EN
  always_comb begin
    if ({6'd0, level_q} >= 16'(STEP_DIV)) step_last = 16'd0;
    else                                  step_last = 16'(STEP_DIV) - {6'd0, level_q};
  end
`else
  assign step_last = 16'(STEP_DIV - 1);
`endif

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    score_d    = score_q;
    lives_d    = lives_q;
    div_cnt_d  = div_cnt_q;
    bar_cnt_d  = bar_cnt_q;
    hold_cnt_d = hold_cnt_q;
    env_step_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.btn_start) begin
          state_d    = S_PLAY;
          level_d    = 10'd1;
          score_d    = 10'd0;
          lives_d    = 2'(LIVES);
          div_cnt_d  = 16'd0;
          bar_cnt_d  = 16'd0;
          hold_cnt_d = 16'd0;
        end
      end
      S_PLAY: begin
        if (bus.collision) begin
          state_d = S_CRASH;
          lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
        end else if (bus.btn_pause) begin
          state_d = S_PAUSED;
        end else begin
          if (bus.frame_tick) begin
            if (div_cnt_q >= step_last) begin
              div_cnt_d  = 16'd0;
              env_step_d = 1'b1;
            end else begin
              div_cnt_d = div_cnt_q + 16'd1;
            end
          end
          if (bus.bar_passed) begin
            score_d = sat_inc10(score_q);
            if (bar_cnt_q == 16'(BARS_PER_LEVEL - 1)) begin
              // Leaving PLAY this cycle, so a coincident tick must not step.
              state_d    = S_LEVEL_UP;
              env_step_d = 1'b0;
            end else begin
              bar_cnt_d = bar_cnt_q + 16'd1;
            end
          end
        end
      end
      S_PAUSED: begin
        if (bus.btn_pause) state_d = S_PLAY;
      end
      S_CRASH: begin
        if (bus.frame_tick) begin
          if (hold_cnt_q == 16'(CRASH_HOLD - 1)) begin
            hold_cnt_d = 16'd0;
            if (lives_q == 2'd0) begin
              state_d = S_OVER;
            end else begin
              state_d   = S_PLAY;
              bar_cnt_d = 16'd0;
              div_cnt_d = 16'd0;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + 16'd1;
          end
        end
      end
      S_LEVEL_UP: begin
        if (level_q < 10'(MAX_LEVEL)) level_d = level_q + 10'd1;
        bar_cnt_d = 16'd0;
        div_cnt_d = 16'd0;
        state_d   = S_PLAY;
      end
      S_OVER: begin
        if (bus.btn_start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs follow the next state so they are valid with it.
    pause_d     = (state_d != S_PLAY);
    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pause_q     <= 1'b1;
      env_step_q  <= 1'b0;
      game_over_q <= 1'b0;
      level_q     <= 10'd1;
      score_q     <= 10'd0;
      lives_q     <= 2'(LIVES);
      div_cnt_q   <= 16'd0;
      bar_cnt_q   <= 16'd0;
      hold_cnt_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      pause_q     <= pause_d;
      env_step_q  <= env_step_d;
      game_over_q <= game_over_d;
      level_q     <= level_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      div_cnt_q   <= div_cnt_d;
      bar_cnt_q   <= bar_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.pause     = pause_q;
  assign bus.env_step  = env_step_q;
  assign bus.game_over = game_over_q;
  assign bus.level     = level_q;
  assign bus.score     = score_q;
  assign bus.lives     = lives_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer
//   Directed scenarios followed by randomized play, all compared cycle by
//   cycle against a behavioural game model held in plain integers.
module tb_game_sequencer;
  localparam int BPL        = 8;
  localparam int MAX_LEVEL  = 9;
  localparam int LIVES      = 3;
  localparam int STEP_DIV   = 4;
  localparam int CRASH_HOLD = 60;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  game_sequencer_if bus();

  game_sequencer #(
    .BARS_PER_LEVEL(BPL), .MAX_LEVEL(MAX_LEVEL), .LIVES(LIVES),
    .STEP_DIV(STEP_DIV), .CRASH_HOLD(CRASH_HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: mode uses the published state codes; counters count events.
  int m_mode, m_level, m_score, m_lives, m_ticks, m_bars, m_hold, m_step;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int divider(input int lvl);
    int d;
`ifdef GAME_SEQUENCER_SPEEDUP_EN
    d = STEP_DIV - (lvl - 1);
    if (d < 1) d = 1;
`else
    d = STEP_DIV;
`endif
    return d;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_level = 1; m_score = 0; m_lives = LIVES;
    m_ticks = 0; m_bars = 0; m_hold = 0; m_step = 0;
  endtask

  task automatic model_step(input bit st, input bit ps, input bit col,
                            input bit bp, input bit ft);
    m_step = 0;
    case (m_mode)
      0: if (st) begin
        m_mode = 1; m_level = 1; m_score = 0; m_lives = LIVES;
        m_ticks = 0; m_bars = 0; m_hold = 0;
      end
      1: begin
        if (col) begin
          m_mode = 3;
          if (m_lives > 0) m_lives = m_lives - 1;
        end else if (ps) begin
          m_mode = 2;
        end else begin
          if (bp) begin
            if (m_score < 1023) m_score = m_score + 1;
            m_bars = m_bars + 1;
          end
          if (m_bars == BPL) begin
            m_mode = 4;
          end else if (ft) begin
            m_ticks = m_ticks + 1;
            if (m_ticks >= divider(m_level)) begin
              m_ticks = 0;
              m_step  = 1;
            end
          end
        end
      end
      2: if (ps) m_mode = 1;
      3: if (ft) begin
        m_hold = m_hold + 1;
        if (m_hold == CRASH_HOLD) begin
          m_hold = 0;
          if (m_lives == 0) m_mode = 5;
          else begin m_mode = 1; m_bars = 0; m_ticks = 0; end
        end
      end
      4: begin
        if (m_level < MAX_LEVEL) m_level = m_level + 1;
        m_bars = 0; m_ticks = 0; m_mode = 1;
      end
      5: if (st) m_mode = 0;
      default: m_mode = 0;
    endcase
  endtask

  task automatic compare_all();
    chk("state",     bus.state,     m_mode);
    chk("pause",     bus.pause,     (m_mode != 1));
    chk("env_step",  bus.env_step,  m_step);
    chk("level",     bus.level,     m_level);
    chk("score",     bus.score,     m_score);
    chk("lives",     bus.lives,     m_lives);
    chk("game_over", bus.game_over, (m_mode == 5));
  endtask

  int steps_seen;

  // One clock: drive at negedge, model advances, compare at next negedge.
  task automatic cyc(input bit st, input bit ps, input bit col, input bit bp, input bit ft);
    bus.btn_start  = st;
    bus.btn_pause  = ps;
    bus.collision  = col;
    bus.bar_passed = bp;
    bus.frame_tick = ft;
    model_step(st, ps, col, bp, ft);
    @(negedge clk);
    compare_all();
    steps_seen += int'(bus.env_step);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  // Async reset raised between edges; outputs must clear before any clock.
  task automatic async_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_state",    bus.state,    0);
    chk("arst_pause",    bus.pause,    1);
    chk("arst_env_step", bus.env_step, 0);
    chk("arst_lives",    bus.lives,    LIVES);
    chk("arst_score",    bus.score,    0);
    model_reset();
    bus.btn_start = 0; bus.btn_pause = 0; bus.collision = 0;
    bus.bar_passed = 0; bus.frame_tick = 0;
    @(negedge clk);
    compare_all();
    rst = 1'b0;
  endtask

  int col_left;

  initial begin
    bus.btn_start = 0; bus.btn_pause = 0; bus.collision = 0;
    bus.bar_passed = 0; bus.frame_tick = 0;
    model_reset();
    @(negedge clk);
    async_reset();
    idle(2);

    // Start, then 8 frame ticks -> exactly two env_step pulses.
    cyc(1, 0, 0, 0, 0);
    chk("start_state", bus.state, 1);
    steps_seen = 0;
    for (int i = 0; i < 8; i++) begin cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0); end
    chk("two_steps", steps_seen, 2);

    // Eight bars -> LEVEL_UP for one cycle, then level 2.
    for (int i = 0; i < 7; i++) begin cyc(0, 0, 0, 1, 0); idle(1); end
    cyc(0, 0, 0, 1, 1);
    chk("lvlup_state", bus.state, 4);
    idle(1);
    chk("lvl2", bus.level, 2);
    chk("score8", bus.score, 8);

    // Many more bars; level saturates at MAX_LEVEL.
    for (int i = 0; i < 80; i++) begin cyc(0, 0, 0, 1, i % 3 == 0); idle(1); end
    chk("lvl_sat", bus.level, MAX_LEVEL);

    // Pause: no steps, bars ignored, resume.
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 0, 1, 1);
    chk("paused", bus.state, 2);
    steps_seen = 0;
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 1, 1);
    chk("paused_nostep", steps_seen, 0);
    cyc(0, 1, 0, 0, 0);
    chk("resumed", bus.state, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1);

    // Collision with simultaneous bar: crash, lose a life, no score.
    cyc(0, 0, 1, 1, 1);
    chk("crash_state", bus.state, 3);
    chk("crash_lives", bus.lives, LIVES - 1);
    for (int i = 0; i < CRASH_HOLD; i++) begin cyc(0, 0, 0, 0, 1); idle(1); end
    chk("crash_back", bus.state, 1);
    chk("crash_unpause", bus.pause, 0);

    // Crash until the game is over.
    for (int k = 0; k < 5; k++) begin
      if (m_mode != 5) begin
        cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < CRASH_HOLD; i++) cyc(0, 0, 0, 0, 1);
      end
    end
    chk("over_state", bus.state, 5);
    chk("over_flag", bus.game_over, 1);
    chk("over_lives", bus.lives, 0);
    cyc(1, 0, 0, 0, 0);
    chk("over_idle", bus.state, 0);
    cyc(1, 0, 0, 0, 0);
    chk("new_level", bus.level, 1);
    chk("new_score", bus.score, 0);
    chk("new_lives", bus.lives, LIVES);

    // Reset in the middle of a crash hold.
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 1);
    async_reset();

    // Randomized play against the model.
    col_left = 0;
    for (int n = 0; n < 20000; n++) begin
      bit st, ps, col, bp, ft;
      st = ($urandom_range(0, 29) == 0);
      ps = ($urandom_range(0, 39) == 0);
      bp = ($urandom_range(0, 3) == 0);
      ft = ($urandom_range(0, 1) == 0);
      if (col_left > 0) begin
        col = 1; col_left--;
      end else begin
        col = 0;
        if ($urandom_range(0, 79) == 0) col_left = $urandom_range(1, 3);
      end
      cyc(st, ps, col, bp, ft);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
